bldc_count_sampler: RTL and testbench

- Sits directly downstream of the BLDC motor block and consumes its free-running enc_count/hall_count outputs.
- On a fixed sample period, converts the counts into signed per-period deltas, handling wrap-around, and presents them to the SPI register layer through a valid/ack handshake.
- Also flags overrun (host missed a sample) and stall (enabled motor with no hall motion) for the control loop.

---
 rtl/bldc_sampler_pkg.sv | 49 ++++
 rtl/bldc_count_sampler_if.sv | 31 +++
 rtl/bldc_sample_timer.sv | 30 +++
 rtl/bldc_count_sampler.sv | 134 +++++++++++++
 tb/tb_bldc_count_sampler.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bldc_sampler_pkg.sv
// rtl/bldc_sampler_pkg.sv - shared state type, default widths and delta arithmetic for the count sampler
package bldc_sampler_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_OVR   = 2'd2
    } sample_state_e;

    localparam int ENC_W_DEFAULT  = 15;
    localparam int HALL_W_DEFAULT = 7;

    // Values travel in 32-bit containers and w (2..31) selects the working width.
    // Difference of two free-running W-bit counts, reduced modulo 2^w and
    // returned sign-extended so the caller can truncate back to w bits.
    function automatic logic signed [31:0] wrap_delta(input logic [31:0] cur,
                                                      input logic [31:0] prev,
                                                      input int unsigned w);
        logic [31:0] mask;
        logic [31:0] d;
        mask = (32'd1 << w) - 32'd1;
        d    = (cur - prev) & mask;
        if (((d >> (w - 1)) & 32'd1) != 32'd0) begin
            d = d | ~mask;
        end
        return $signed(d);
    endfunction

    // Signed add of two sign-extended w-bit values, clamped to the w-bit range.
    // The sum of two w-bit values needs at most w+1 significant bits.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned w);
        logic signed [31:0] sum;
        logic signed [31:0] max_v;
        logic signed [31:0] min_v;
        max_v = $signed((32'd1 << (w - 1)) - 32'd1);
        min_v = -max_v - 32'sd1;
        sum   = a + b;
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/bldc_count_sampler_if.sv
// rtl/bldc_count_sampler_if.sv - count inputs and sample handshake bundle for the count sampler
//   slave : sampler side (counts/en/ack in, sample outputs out)
//   master: motor block + register layer side
interface bldc_count_sampler_if
    import bldc_sampler_pkg::*;
#(
    parameter int ENCODER_COUNT_WIDTH = ENC_W_DEFAULT,
    parameter int HALL_COUNT_WIDTH    = HALL_W_DEFAULT
);
    logic                           en;
    logic                           counts_cleared;
    logic [ENCODER_COUNT_WIDTH-1:0] enc_count;
    logic [HALL_COUNT_WIDTH-1:0]    hall_count;
    logic                           sample_ack;
    logic                           sample_valid;
    logic [ENCODER_COUNT_WIDTH-1:0] enc_delta;
    logic [HALL_COUNT_WIDTH-1:0]    hall_delta;
    logic [7:0]                     sample_seq;
    logic                           overrun;
    logic                           stall;

    modport slave (
        input  en, counts_cleared, enc_count, hall_count, sample_ack,
        output sample_valid, enc_delta, hall_delta, sample_seq, overrun, stall
    );

    modport master (
        output en, counts_cleared, enc_count, hall_count, sample_ack,
        input  sample_valid, enc_delta, hall_delta, sample_seq, overrun, stall
    );
endinterface

// File: rtl/bldc_sample_timer.sv
// rtl/bldc_sample_timer.sv - free-running sample period counter with one-cycle terminal-count tick
//   clk, reset : clock, synchronous active-high reset
//   tick_o     : high for one cycle when the counter sits at SAMPLE_PERIOD-1
module bldc_sample_timer #(
    parameter int SAMPLE_PERIOD = 18432
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);
    localparam int CW = $clog2(SAMPLE_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bldc_count_sampler.sv
// rtl/bldc_count_sampler.sv - periodic signed delta sampler for BLDC encoder/hall counts with overrun and stall flags
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of bldc_count_sampler_if (counts in, deltas/seq/flags out, valid/ack)
module bldc_count_sampler
    import bldc_sampler_pkg::*;
#(
    parameter int ENCODER_COUNT_WIDTH = ENC_W_DEFAULT,
    parameter int HALL_COUNT_WIDTH    = HALL_W_DEFAULT,
    parameter int SAMPLE_PERIOD       = 18432,
    parameter int STALL_LIMIT         = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    bldc_count_sampler_if.slave  bus
);
    localparam int EW = ENCODER_COUNT_WIDTH;
    localparam int HW = HALL_COUNT_WIDTH;
    localparam int ZW = $clog2(STALL_LIMIT + 1);
    localparam logic [ZW-1:0] ZLIM = ZW'(STALL_LIMIT);

    logic tick;

    sample_state_e        state_q, state_d;
    logic signed [EW-1:0] enc_delta_q, enc_delta_d;
    logic signed [HW-1:0] hall_delta_q, hall_delta_d;
    logic [EW-1:0]        prev_enc_q, prev_enc_d;
    logic [HW-1:0]        prev_hall_q, prev_hall_d;
    logic [7:0]           seq_q, seq_d;
    logic [ZW-1:0]        zero_run_q, zero_run_d;

    logic signed [EW-1:0] enc_raw, enc_sum;
    logic signed [HW-1:0] hall_raw, hall_sum;

    bldc_sample_timer #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick_o(tick)
    );

    always_comb begin
        enc_raw  = EW'(wrap_delta(32'(bus.enc_count), 32'(prev_enc_q), EW));
        hall_raw = HW'(wrap_delta(32'(bus.hall_count), 32'(prev_hall_q), HW));
        enc_sum  = EW'(sat_add(32'(enc_delta_q), 32'(enc_raw), EW));
        hall_sum = HW'(sat_add(32'(hall_delta_q), 32'(hall_raw), HW));
    end

    // Handshake FSM: a tick with ack pending replaces the held sample rather
    // than merging into it, because the host has already taken the old one.
    always_comb begin
        state_d      = state_q;
        enc_delta_d  = enc_delta_q;
        hall_delta_d = hall_delta_q;
        case (state_q)
            ST_EMPTY: begin
                if (tick) begin
                    enc_delta_d  = enc_raw;
                    hall_delta_d = hall_raw;
                    state_d      = ST_FULL;
                end
            end
            ST_FULL, ST_OVR: begin
                if (tick && bus.sample_ack) begin
                    enc_delta_d  = enc_raw;
                    hall_delta_d = hall_raw;
                    state_d      = ST_FULL;
                end else if (tick) begin
                    enc_delta_d  = enc_sum;
                    hall_delta_d = hall_sum;
                    state_d      = ST_OVR;
                end else if (bus.sample_ack) begin
                    state_d      = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        seq_d = tick ? seq_q + 8'd1 : seq_q;

        // An upstream counter clear wins over the tick reload; the delta
        // captured in that same cycle still used the old prev value.
        prev_enc_d  = prev_enc_q;
        prev_hall_d = prev_hall_q;
        if (bus.counts_cleared) begin
            prev_enc_d  = '0;
            prev_hall_d = '0;
        end else if (tick) begin
            prev_enc_d  = bus.enc_count;
            prev_hall_d = bus.hall_count;
        end

        zero_run_d = zero_run_q;
        if (!bus.en) begin
            zero_run_d = '0;
        end else if (tick) begin
            if (hall_raw != '0) begin
                zero_run_d = '0;
            end else if (zero_run_q < ZLIM) begin
                zero_run_d = zero_run_q + ZW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            enc_delta_q  <= '0;
            hall_delta_q <= '0;
            seq_q        <= '0;
            zero_run_q   <= '0;
            // First delta after reset is measured from the counts present now.
            prev_enc_q   <= bus.enc_count;
            prev_hall_q  <= bus.hall_count;
        end else begin
            state_q      <= state_d;
            enc_delta_q  <= enc_delta_d;
            hall_delta_q <= hall_delta_d;
            seq_q        <= seq_d;
            zero_run_q   <= zero_run_d;
            prev_enc_q   <= prev_enc_d;
            prev_hall_q  <= prev_hall_d;
        end
    end

    assign bus.sample_valid = (state_q != ST_EMPTY);
    assign bus.overrun      = (state_q == ST_OVR);
    assign bus.enc_delta    = enc_delta_q;
    assign bus.hall_delta   = hall_delta_q;
    assign bus.sample_seq   = seq_q;
    assign bus.stall        = (zero_run_q >= ZLIM);
endmodule

// File: tb/tb_bldc_count_sampler.sv
// tb/tb_bldc_count_sampler.sv - self-checking bench for bldc_count_sampler with behavioural model
module tb_bldc_count_sampler;
    localparam int EW = 15;
    localparam int HW = 7;
    localparam int P  = 16;
    localparam int SL = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bldc_count_sampler_if #(.ENCODER_COUNT_WIDTH(EW), .HALL_COUNT_WIDTH(HW)) bus ();

    bldc_count_sampler #(
        .ENCODER_COUNT_WIDTH(EW),
        .HALL_COUNT_WIDTH   (HW),
        .SAMPLE_PERIOD      (P),
        .STALL_LIMIT        (SL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state (plain integers)
    int m_t = 0;
    int m_pe = 0;
    int m_ph = 0;
    int m_valid = 0;
    int m_ovr = 0;
    int m_e = 0;
    int m_h = 0;
    int m_seq = 0;
    int m_zr = 0;
    int m_armed = 0;

    function automatic int wrapd(input int cur, input int prev, input int w);
        int m;
        int d;
        m = 1 << w;
        d = (((cur - prev) % m) + m) % m;
        if (d >= m / 2) d = d - m;
        return d;
    endfunction

    function automatic int clampw(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sd_enc();
        return int'($signed(bus.enc_delta));
    endfunction

    function automatic int sd_hall();
        return int'($signed(bus.hall_delta));
    endfunction

    always @(posedge clk) begin
        int cur_e;
        int cur_h;
        int de;
        int dh;
        int tk;
        cur_e = int'(bus.enc_count);
        cur_h = int'(bus.hall_count);
        if (reset) begin
            m_t = 0; m_pe = cur_e; m_ph = cur_h;
            m_valid = 0; m_ovr = 0; m_e = 0; m_h = 0; m_seq = 0; m_zr = 0;
            m_armed = 1;
        end else begin
            tk  = (m_t == P - 1) ? 1 : 0;
            m_t = (m_t + 1) % P;
            de  = wrapd(cur_e, m_pe, EW);
            dh  = wrapd(cur_h, m_ph, HW);
            if (tk != 0) begin
                m_seq = (m_seq + 1) % 256;
                if (m_valid == 0 || bus.sample_ack) begin
                    m_e = de; m_h = dh; m_valid = 1; m_ovr = 0;
                end else begin
                    m_e = clampw(m_e + de, EW); m_h = clampw(m_h + dh, HW); m_ovr = 1;
                end
            end else if (bus.sample_ack && m_valid != 0) begin
                m_valid = 0; m_ovr = 0;
            end
            if (bus.counts_cleared) begin
                m_pe = 0; m_ph = 0;
            end else if (tk != 0) begin
                m_pe = cur_e; m_ph = cur_h;
            end
            if (!bus.en) m_zr = 0;
            else if (tk != 0) m_zr = (dh == 0) ? ((m_zr + 1 > SL) ? SL : m_zr + 1) : 0;
        end
    end

    always @(negedge clk) begin
        if (m_armed != 0) begin
            check("cyc_valid", int'(bus.sample_valid), m_valid);
            check("cyc_overrun", int'(bus.overrun), m_ovr);
            check("cyc_seq", int'(bus.sample_seq), m_seq);
            check("cyc_stall", int'(bus.stall), (m_zr >= SL) ? 1 : 0);
            if (m_valid != 0) begin
                check("cyc_enc_delta", sd_enc(), m_e);
                check("cyc_hall_delta", sd_hall(), m_h);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of a cycle whose closing edge is a tick.
    task automatic to_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (m_t != P - 1 && n < 2 * P) begin
            @(negedge clk);
            n++;
        end
        if (m_t != P - 1) begin
            checks++;
            errors++;
            $display("FAIL to_tick: no terminal count within %0d cycles", 2 * P);
        end
    endtask

    initial begin
        bus.en = 1'b0;
        bus.counts_cleared = 1'b0;
        bus.enc_count = 15'd32760;
        bus.hall_count = 7'd0;
        bus.sample_ack = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        check("rst_valid", int'(bus.sample_valid), 0);
        check("rst_seq", int'(bus.sample_seq), 0);
        check("rst_enc", sd_enc(), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        check("rst_stall", int'(bus.stall), 0);
        reset = 1'b0;

        // Forward wrap 32760 -> 5
        to_tick(); bus.enc_count = 15'd5; step();
        check("wrap_fwd_valid", int'(bus.sample_valid), 1);
        check("wrap_fwd_delta", sd_enc(), 13);
        repeat (4) step();
        bus.sample_ack = 1'b1; step(); bus.sample_ack = 1'b0;
        check("ack_valid_fall", int'(bus.sample_valid), 0);

        // Reverse wrap 5 -> 32760
        to_tick(); bus.enc_count = 15'd32760; step();
        check("wrap_rev_delta", sd_enc(), -13);
        check("wrap_rev_seq", int'(bus.sample_seq), 2);
        bus.sample_ack = 1'b1; step(); bus.sample_ack = 1'b0;
        bus.sample_ack = 1'b1; step(); bus.sample_ack = 1'b0; step();
        check("ack_empty_valid", int'(bus.sample_valid), 0);
        check("ack_empty_seq", int'(bus.sample_seq), 2);

        // Overrun merge +10 then +7
        to_tick(); bus.enc_count = 15'd2; step();
        check("ovr_first", sd_enc(), 10);
        to_tick(); bus.enc_count = 15'd9; step();
        check("ovr_merge", sd_enc(), 17);
        check("ovr_flag", int'(bus.overrun), 1);
        check("ovr_seq", int'(bus.sample_seq), 4);
        bus.sample_ack = 1'b1; step(); bus.sample_ack = 1'b0;
        check("ovr_ack_flag", int'(bus.overrun), 0);
        check("ovr_ack_valid", int'(bus.sample_valid), 0);

        // Saturation, then ack coincident with tick
        to_tick(); bus.enc_count = 15'd16009; step();
        check("sat_held", sd_enc(), 16000);
        to_tick(); bus.enc_count = 15'd17009; step();
        check("sat_clamp", sd_enc(), 16383);
        to_tick(); bus.enc_count = 15'd17014; bus.sample_ack = 1'b1; step(); bus.sample_ack = 1'b0;
        check("coinc_delta", sd_enc(), 5);
        check("coinc_overrun", int'(bus.overrun), 0);
        check("coinc_valid", int'(bus.sample_valid), 1);
        bus.sample_ack = 1'b1; step(); bus.sample_ack = 1'b0;

        // Stall detection
        bus.en = 1'b1; bus.sample_ack = 1'b1; step();
        for (int k = 1; k <= 3; k++) begin
            to_tick(); step();
            check("stall_build", int'(bus.stall), (k >= SL) ? 1 : 0);
        end
        to_tick(); bus.hall_count = 7'd1; step();
        check("stall_motion", int'(bus.stall), 0);
        check("stall_hall_delta", sd_hall(), 1);
        repeat (3) begin
            to_tick(); step();
        end
        check("stall_again", int'(bus.stall), 1);
        bus.en = 1'b0; step();
        check("stall_en_low", int'(bus.stall), 0);
        bus.sample_ack = 1'b0; step();

        // Reset while a sample is held
        to_tick(); bus.enc_count = 15'd17100; step();
        check("rstmid_full", int'(bus.sample_valid), 1);
        bus.enc_count = 15'd1000; bus.hall_count = 7'd5; reset = 1'b1; step(); reset = 1'b0;
        check("rstmid_valid", int'(bus.sample_valid), 0);
        check("rstmid_enc", sd_enc(), 0);
        check("rstmid_hall", sd_hall(), 0);
        check("rstmid_seq", int'(bus.sample_seq), 0);
        to_tick(); bus.enc_count = 15'd1050; bus.hall_count = 7'd7; step();
        check("rstmid_rel_enc", sd_enc(), 50);
        check("rstmid_rel_hall", sd_hall(), 2);

        // Upstream counter clear
        bus.sample_ack = 1'b1; step(); bus.sample_ack = 1'b0;
        bus.enc_count = 15'd0; bus.hall_count = 7'd0; bus.counts_cleared = 1'b1; step();
        bus.counts_cleared = 1'b0;
        to_tick(); bus.enc_count = 15'd25; bus.hall_count = 7'd3; step();
        check("clr_enc", sd_enc(), 25);
        check("clr_hall", sd_hall(), 3);

        // Randomised traffic checked by the per-cycle compare process
        for (int i = 0; i < 4000; i++) begin
            int r;
            reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 63) == 0) bus.en = ~bus.en;
            bus.counts_cleared = ($urandom_range(0, 49) == 0);
            bus.sample_ack = ($urandom_range(0, 4) == 0);
            r = int'($urandom_range(0, 15));
            if (r == 0) bus.enc_count = 15'($urandom);
            else if (r < 6) bus.enc_count = bus.enc_count + 15'($urandom_range(0, 40)) - 15'd20;
            if ($urandom_range(0, 29) == 0) bus.hall_count = bus.hall_count + 7'($urandom_range(1, 5));
            if ($urandom_range(0, 199) == 0) bus.hall_count = 7'($urandom);
            step();
        end
        reset = 1'b0; bus.sample_ack = 1'b0; bus.counts_cleared = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
